// File: rtl/input_packer_pkg.sv
// Shared constants and helpers for the input packer: default word width,
// default lane count, and the width of the fill counter / lane-count field.
package input_packer_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_LANES = 8;

  // Width able to hold 0..lanes, used for both the fill counter and out_lanes.
  function automatic int lane_cnt_width(input int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/input_packer_out_reg.sv
// Output holding register for the input packer. Holds one packed vector and
// its real-lane count, presents it with out_valid, and can drain and reload
// in the same cycle so back-to-back vectors flow without a bubble.
module pack_out_reg
  import input_packer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LANES = DEFAULT_LANES,
  parameter int CW    = lane_cnt_width(LANES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i [LANES],
  input  logic [CW-1:0]    load_lanes_i,
  input  logic             out_ready_i,
  output logic             loadable_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o [LANES],
  output logic [CW-1:0]    out_lanes_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q  [LANES];
  logic [WIDTH-1:0] data_d  [LANES];
  logic [CW-1:0]    lanes_q, lanes_d;

  // Empty, or being drained this cycle: either way a new vector may land.
  assign loadable_o = !valid_q || out_ready_i;

  // Next-state: load wins over drain; data and count hold otherwise.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    valid_d = valid_q;
    data_d  = data_q;
    lanes_d = lanes_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = load_data_i;
      lanes_d = load_lanes_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      lanes_q <= '0;
      // NOTE: the vector register is reset on purpose: consumers may observe
      // out_data while in reset and must see zeros, so it is not a free-running store.
      for (int i = 0; i < LANES; i++) data_q[i] <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      valid_q <= valid_d;
      data_q  <= data_d;
      lanes_q <= lanes_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_lanes_o = lanes_q;

endmodule

// File: rtl/input_packer.sv
// Input packer: collects WIDTH-bit words into LANES-wide vectors, lane 0 being
// the first word accepted. A completed group is handed to pack_out_reg.
// Optional feature macro INPUT_PACKER_FLUSH_EN adds a flush input that emits
// a partial group zero-padded, with out_lanes giving the real lane count.
module input_packer
  import input_packer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LANES = DEFAULT_LANES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data [LANES],
  output logic [$clog2(LANES+1)-1:0] out_lanes
`ifdef INPUT_PACKER_FLUSH_EN
  ,
  input  logic                       flush
`endif
);

  localparam int CW = lane_cnt_width(LANES);
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  // The last lane never needs storage: it is taken straight from in_data.
  logic [WIDTH-1:0] coll_q [LANES-1];
  logic [WIDTH-1:0] coll_d [LANES-1];

  logic             loadable;
  logic             accept;
  logic             complete;
  logic             flush_fire;
  logic             load;
  logic [WIDTH-1:0] load_data [LANES];
  logic [CW-1:0]    load_lanes;

  // Only the group-completing word can be blocked, and only while the output is stuck.
  assign in_ready = (cnt_q != LAST) || loadable;
  assign accept   = in_valid && in_ready;
  assign complete = accept && (cnt_q == LAST);

`ifdef INPUT_PACKER_FLUSH_EN
  // A completing word already emits the full vector, so flush adds nothing then.
  assign flush_fire = flush && loadable && !complete && ((cnt_q != '0) || accept);
`else
  assign flush_fire = 1'b0;
`endif

  assign load = complete || flush_fire;
  // Collected words plus this cycle's word; equals LANES on completion.
  assign load_lanes = cnt_q + CW'(accept);

  // Build the outgoing vector: stored lanes, then this cycle's word, then zero padding.
  always_comb begin
    for (int i = 0; i < LANES - 1; i++) begin
      if (CW'(i) < cnt_q)                 load_data[i] = coll_q[i];
      else if (accept && cnt_q == CW'(i)) load_data[i] = in_data;
      else                                load_data[i] = '0;
    end
    load_data[LANES-1] = complete ? in_data : '0;
  end

  // Next-state for the collection lanes and fill counter.
  always_comb begin
    coll_d = coll_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < LANES - 1; i++) begin
      if (accept && cnt_q == CW'(i)) coll_d[i] = in_data;
    end
    if (load)        cnt_d = '0;
    else if (accept) cnt_d = cnt_q + 1'b1;
  end

  // Collection state; reset discards any partial group.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      for (int i = 0; i < LANES - 1; i++) coll_q[i] <= '0;
    end else begin
      cnt_q  <= cnt_d;
      coll_q <= coll_d;
    end
  end

  pack_out_reg #(
    .WIDTH (WIDTH),
    .LANES (LANES),
    .CW    (CW)
  ) u_out_reg (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load),
    .load_data_i  (load_data),
    .load_lanes_i (load_lanes),
    .out_ready_i  (out_ready),
    .loadable_o   (loadable),
    .out_valid_o  (out_valid),
    .out_data_o   (out_data),
    .out_lanes_o  (out_lanes)
  );

endmodule

// File: doc/input_packer.md
INPUT_PACKER -- requirements
Module: input_packer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width in bits of each word.
REQ-002 SHALL have parameter LANES, default 8, words per output vector; legal values 2..64.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  in_data holds a word.
REQ-006 SHALL have port in_ready  output  1  packer accepts a word this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  incoming word.
REQ-008 SHALL have port out_valid  output  1  out_data holds a complete vector.
REQ-009 SHALL have port out_ready  input  1  consumer takes the vector this cycle; tie high for a handshake-free add tree.
REQ-010 SHALL have port out_data  output  LANES x WIDTH unpacked array  packed vector, lane 0 = first word accepted.
REQ-011 SHALL have port out_lanes  output  $clog2(LANES+1)  number of real (non-padded) lanes in out_data.

Function
REQ-012 A word SHALL be accepted when in_valid and in_ready are both 1; accepted words fill lanes 0..LANES-1 in order, tracked by fill count cnt (0..LANES-1).
REQ-013 Accepting a word with cnt<LANES-1 SHALL store it in lane cnt and increment cnt.
REQ-014 Accepting a word with cnt=LANES-1 SHALL load the output register with all LANES lanes, set out_lanes=LANES, and wrap cnt to 0; out_valid=1 on the next cycle (latency 1 from last word).
REQ-015 The output register SHALL be loadable when out_valid=0 or out_ready=1 (drain and load in the same cycle; no bubble).
REQ-016 in_ready SHALL be 0 only when cnt=LANES-1 and the output register is not loadable; otherwise 1.
REQ-017 A vector transfer SHALL occur when out_valid and out_ready are both 1; with no new load, out_valid falls the next cycle.
REQ-018 out_data and out_lanes SHALL stay stable while out_valid=1 and out_ready=0.
REQ-019 Word and lane values SHALL pass unmodified; no arithmetic on data.

Reset
REQ-020 While rst=1: cnt=0, out_valid=0, out_data all lanes 0, out_lanes=0, collecting lanes 0, flush state cleared.
REQ-021 Reset mid-group SHALL discard partially collected words; no vector is emitted for them.
REQ-022 in_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-023 Macro INPUT_PACKER_FLUSH_EN defined: SHALL add port flush  input  1  request to emit the partial group.
REQ-024 With flush=1, cnt>0 (counting a word accepted that cycle) and output register loadable: SHALL load lanes 0..n-1 with collected words, lanes n..LANES-1 with 0, out_lanes=n, cnt=0.
REQ-025 Flush with an accepted word that completes a group SHALL behave exactly as REQ-014.
REQ-026 Flush with cnt=0 and no word accepted SHALL be a no-op; flush while output register not loadable SHALL be ignored that cycle (requester holds flush).
REQ-027 Macro undefined: no flush port; out_lanes SHALL always equal LANES when out_valid=1.

Structure
REQ-028 Package input_packer_pkg SHALL hold the default WIDTH and LANES constants and a function computing the cnt/out_lanes width.
REQ-029 Sub-module pack_out_reg SHALL implement the output holding register with its valid/ready load logic; collection and fill counter remain in input_packer.

Verification
REQ-030 Reset, then 8 words 1..8 back-to-back, out_ready=1 -> one cycle after the 8th word, out_valid=1, out_data={1..8}, out_lanes=8.
REQ-031 24 continuous words, out_ready=1 -> 3 vectors, in_ready never 0, vectors every 8 cycles.
REQ-032 Vector pending with out_ready=0, 7 more words sent -> 8th word stalls (in_ready=0), first vector held stable; out_ready=1 -> drain and reload in one cycle.
REQ-033 FLUSH_EN: words 10,20,30 then flush -> out_data={10,20,30,0,0,0,0,0}, out_lanes=3, cnt=0.
REQ-034 Assert rst after 5 words, release, send 8 words 100..107 -> single vector {100..107}; no vector containing pre-reset words.
REQ-035 Random in_valid/out_ready, 1000 words -> output stream equals input stream in order, no loss or duplication.
